// File: rtl/mem_bus_pkg.sv
// Shared types for the I/D memory bus arbiter.
//   arb_state_e : transaction sequencer states
//   gnt_e       : which requester owns the RAM
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } gnt_e;

  // Wide enough for the longest wait phase (MEM_LAT up to 4 -> 3 wait cycles).
  localparam int unsigned WaitCntW = 2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the fetch (I) and load/store (D) ports.
// Optional feature macro: ARB_RR_EN
//   defined   : a tie goes to the port that was not granted last
//   undefined : fixed priority, D beats I; last_gnt_i is ignored
// Ports:
//   i_req_i    : fetch request
//   d_req_i    : data request
//   last_gnt_i : port granted most recently (only used for round-robin)
//   gnt_o      : winner, GNT_NONE when nobody requests
module arb_pick
  import mem_bus_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  gnt_e last_gnt_i,
  output gnt_e gnt_o
);

`ifdef ARB_RR_EN
  always_comb begin
    gnt_o = GNT_NONE;
    if (i_req_i && d_req_i) begin
      gnt_o = (last_gnt_i == GNT_D) ? GNT_I : GNT_D;
    end else if (d_req_i) begin
      gnt_o = GNT_D;
    end else if (i_req_i) begin
      gnt_o = GNT_I;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = ^{last_gnt_i};

  always_comb begin
    gnt_o = GNT_NONE;
    if (d_req_i) begin
      gnt_o = GNT_D;
    end else if (i_req_i) begin
      gnt_o = GNT_I;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port word RAM between the CPU fetch port (I) and load/store port (D).
// Each transaction: IDLE -> ACCESS -> WAIT x (MEM_LAT-1, reads only) -> DONE -> IDLE.
// Optional feature macro: ARB_RR_EN (round-robin on simultaneous requests, else D > I).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_req/i_addr/i_rdata/i_ack : fetch handshake, rdata valid only with ack
//   d_req/d_we/d_be/d_addr/d_wdata/d_rdata/d_ack : load/store handshake
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   : RAM side, read data MEM_LAT cycles after mem_en
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  // Last WAIT cycle index; irrelevant when MEM_LAT=1 because WAIT is skipped.
  localparam int unsigned WaitLastInt = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(WaitLastInt);

  arb_state_e            state_q, state_d;
  gnt_e                  gnt_q, gnt_d;
  gnt_e                  pick;
  gnt_e                  last_gnt;
  logic [WaitCntW-1:0]   cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DATA_W/8-1:0]   be_q, be_d;
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  // Byte-offset bits and bits above the RAM window are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                              d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

  arb_pick u_arb_pick (
    .i_req_i    (i_req),
    .d_req_i    (d_req),
    .last_gnt_i (last_gnt),
    .gnt_o      (pick)
  );

`ifdef ARB_RR_EN
  gnt_e last_gnt_q, last_gnt_d;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_q == IDLE && pick != GNT_NONE) begin
      last_gnt_d = pick;
    end
  end

  // Resets to I so that D wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= GNT_I;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign last_gnt = last_gnt_q;
`else
  assign last_gnt = GNT_I;
`endif

  // State and latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= GNT_NONE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_d = ACCESS;
          gnt_d   = pick;
          if (pick == GNT_D) begin
            we_d    = d_we;
            be_d    = d_be;
            addr_d  = d_addr[MEM_AW+1:2];
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            be_d    = '0;
            addr_d  = i_addr[MEM_AW+1:2];
            wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        cnt_d   = '0;
        // Stores need no read data, so they never wait.
        state_d = (we_q || MEM_LAT == 1) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == WaitLast) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  // Outputs are pure functions of state and latched request (plus RAM data pass-through).
  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = (state_q == ACCESS && we_q) ? be_q : '0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_ack     = (state_q == DONE) && (gnt_q == GNT_I);
    d_ack     = (state_q == DONE) && (gnt_q == GNT_D);
    i_rdata   = i_ack ? mem_rdata : '0;
    d_rdata   = d_ack ? mem_rdata : '0;
  end

endmodule
